rat_reduce: RTL and testbench

Sequential rational normalizer that sits downstream of the rational add/sub/mul units. It accepts an unreduced fraction (signed numerator, unsigned denominator) through a valid/ready handshake. It computes the GCD with a multi-cycle binary (Stein) algorithm and divides both terms by it with iterative restoring division. It returns the fraction in lowest terms with a positive denominator.

---
 rtl/rat_reduce_if.sv | 26 ++
 rtl/rat_reduce.sv | 207 ++++++++++++++++++++
 tb/tb_rat_reduce.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rat_reduce_if.sv
// Handshake bus for rat_reduce: fraction in, reduced fraction out.
interface rat_reduce_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic [WIDTH-1:0] in_den;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_num;
    logic [WIDTH-1:0] out_den;
    logic             out_err;

    // Producer/consumer side (drives fractions, accepts results)
    modport master (
        output in_valid, in_num, in_den, out_ready,
        input  in_ready, out_valid, out_num, out_den, out_err
    );

    // Normalizer side
    modport slave (
        input  in_valid, in_num, in_den, out_ready,
        output in_ready, out_valid, out_num, out_den, out_err
    );
endinterface

// File: rtl/rat_reduce.sv
// Rational normalizer: binary GCD followed by two parallel restoring dividers.
module rat_reduce #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    rat_reduce_if.slave  bus
);
    localparam int unsigned KW = $clog2(WIDTH) + 1;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GCD  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state, state_nxt;
    logic             rdy, rdy_nxt;
    logic             ov, ov_nxt;
    logic [WIDTH-1:0] onum, onum_nxt;
    logic [WIDTH-1:0] oden, oden_nxt;
    logic             oerr, oerr_nxt;
    logic             sign, sign_nxt;
    logic [WIDTH-1:0] mag, mag_nxt;
    logic [WIDTH-1:0] den, den_nxt;
    logic [WIDTH-1:0] a, a_nxt;
    logic [WIDTH-1:0] b, b_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic [WIDTH-1:0] g, g_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] rem_n, rem_n_nxt;
    logic [WIDTH-1:0] rem_d, rem_d_nxt;
    logic [WIDTH-1:0] q_n, q_n_nxt;
    logic [WIDTH-1:0] q_d, q_d_nxt;

    logic [WIDTH:0]   step_n, step_d;
    logic [WIDTH-1:0] qn_sh, qd_sh;

    // One restoring-division step: returns {quotient_bit, new_remainder}.
    // The remainder stays below the divisor, so it always fits WIDTH bits.
    function automatic logic [WIDTH:0] div_step(input logic [WIDTH-1:0] rem,
                                                input logic             bit_in,
                                                input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] diff;
        sh   = {rem, bit_in};
        diff = sh - {1'b0, d};
        if (sh >= {1'b0, d}) begin
            div_step = {1'b1, diff[WIDTH-1:0]};
        end else begin
            div_step = {1'b0, sh[WIDTH-1:0]};
        end
    endfunction

    assign bus.in_ready  = rdy;
    assign bus.out_valid = ov;
    assign bus.out_num   = onum;
    assign bus.out_den   = oden;
    assign bus.out_err   = oerr;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdy   <= 1'b1;
            ov    <= 1'b0;
            onum  <= '0;
            oden  <= '0;
            oerr  <= 1'b0;
            sign  <= 1'b0;
            mag   <= '0;
            den   <= '0;
            a     <= '0;
            b     <= '0;
            k     <= '0;
            g     <= '0;
            cnt   <= '0;
            rem_n <= '0;
            rem_d <= '0;
            q_n   <= '0;
            q_d   <= '0;
        end else begin
            state <= state_nxt;
            rdy   <= rdy_nxt;
            ov    <= ov_nxt;
            onum  <= onum_nxt;
            oden  <= oden_nxt;
            oerr  <= oerr_nxt;
            sign  <= sign_nxt;
            mag   <= mag_nxt;
            den   <= den_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            k     <= k_nxt;
            g     <= g_nxt;
            cnt   <= cnt_nxt;
            rem_n <= rem_n_nxt;
            rem_d <= rem_d_nxt;
            q_n   <= q_n_nxt;
            q_d   <= q_d_nxt;
        end
    end

    // Next-state and datapath update for accept, Stein GCD, divide and hand-off
    always_comb begin
        state_nxt = state;
        ov_nxt    = ov;
        onum_nxt  = onum;
        oden_nxt  = oden;
        oerr_nxt  = oerr;
        sign_nxt  = sign;
        mag_nxt   = mag;
        den_nxt   = den;
        a_nxt     = a;
        b_nxt     = b;
        k_nxt     = k;
        g_nxt     = g;
        cnt_nxt   = cnt;
        rem_n_nxt = rem_n;
        rem_d_nxt = rem_d;
        q_n_nxt   = q_n;
        q_d_nxt   = q_d;

        step_n = div_step(rem_n, mag[WIDTH-1], g);
        step_d = div_step(rem_d, den[WIDTH-1], g);
        qn_sh  = {q_n[WIDTH-2:0], step_n[WIDTH]};
        qd_sh  = {q_d[WIDTH-2:0], step_d[WIDTH]};

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_nxt = bus.in_num[WIDTH-1];
                    mag_nxt  = bus.in_num[WIDTH-1] ? WIDTH'(-bus.in_num) : bus.in_num;
                    den_nxt  = bus.in_den;
                    if (bus.in_den == '0) begin
                        onum_nxt  = bus.in_num;
                        oden_nxt  = '0;
                        oerr_nxt  = 1'b1;
                        ov_nxt    = 1'b1;
                        state_nxt = DONE;
                    end else if (bus.in_num == '0) begin
                        onum_nxt  = '0;
                        oden_nxt  = WIDTH'(1);
                        oerr_nxt  = 1'b0;
                        ov_nxt    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        a_nxt     = bus.in_num[WIDTH-1] ? WIDTH'(-bus.in_num) : bus.in_num;
                        b_nxt     = bus.in_den;
                        k_nxt     = '0;
                        state_nxt = GCD;
                    end
                end
            end
            GCD: begin
                if (a == '0 || b == '0) begin
                    g_nxt     = (a | b) << k;
                    cnt_nxt   = '0;
                    rem_n_nxt = '0;
                    rem_d_nxt = '0;
                    q_n_nxt   = '0;
                    q_d_nxt   = '0;
                    state_nxt = DIV;
                end else if (!a[0] && !b[0]) begin
                    a_nxt = a >> 1;
                    b_nxt = b >> 1;
                    k_nxt = k + KW'(1);
                end else if (!a[0]) begin
                    a_nxt = a >> 1;
                end else if (!b[0]) begin
                    b_nxt = b >> 1;
                end else if (a >= b) begin
                    a_nxt = (a - b) >> 1;
                end else begin
                    b_nxt = (b - a) >> 1;
                end
            end
            DIV: begin
                mag_nxt   = mag << 1;
                den_nxt   = den << 1;
                rem_n_nxt = step_n[WIDTH-1:0];
                rem_d_nxt = step_d[WIDTH-1:0];
                q_n_nxt   = qn_sh;
                q_d_nxt   = qd_sh;
                cnt_nxt   = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    onum_nxt  = sign ? WIDTH'(-qn_sh) : qn_sh;
                    oden_nxt  = qd_sh;
                    oerr_nxt  = 1'b0;
                    ov_nxt    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    ov_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        rdy_nxt = (state_nxt == IDLE);
    end
endmodule

// File: tb/tb_rat_reduce.sv
// Directed scoreboard bench for rat_reduce.
module tb_rat_reduce;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rat_reduce_if #(.WIDTH(W)) bus();

    rat_reduce #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    int   hs_cyc  = 0;
    exp_t sb[$];
    exp_t last_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] euclid(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p, q, t;
        p = x;
        q = y;
        while (q != '0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d);
        exp_t e;
        logic [W-1:0] m, gg, qn;
        if (d == '0) begin
            e.num = n; e.den = '0; e.err = 1'b1;
        end else if (n == '0) begin
            e.num = '0; e.den = W'(1); e.err = 1'b0;
        end else begin
            m  = n[W-1] ? W'(-n) : n;
            gg = euclid(m, d);
            qn = m / gg;
            e.num = n[W-1] ? W'(-qn) : qn;
            e.den = d / gg;
            e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic send(input logic [W-1:0] n, input logic [W-1:0] d);
        sb.push_back(model(n, d));
        bus.in_num   = n;
        bus.in_den   = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !bus.in_ready; i++) tick();
        check("accept_ready", W'(bus.in_ready), W'(1));
        tick();
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, W'(bus.out_valid), W'(1));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, W'(sb.size()), W'(1));
        end else begin
            last_exp = sb.pop_front();
            check({tag, "_num"}, bus.out_num, last_exp.num);
            check({tag, "_den"}, bus.out_den, last_exp.den);
            check({tag, "_err"}, W'(bus.out_err), W'(last_exp.err));
        end
        if (lat >= 0) check({tag, "_latency"}, W'(cyc - acc_cyc), W'(lat));
        check({tag, "_busy"}, W'(bus.in_ready), W'(0));
        if (bus.out_ready) begin
            tick();
            check({tag, "_taken"}, W'(bus.out_valid), W'(0));
            check({tag, "_idle"}, W'(bus.in_ready), W'(1));
        end
    endtask

    initial begin
        int spur;
        bus.in_valid  = 1'b0;
        bus.in_num    = '0;
        bus.in_den    = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", W'(bus.out_valid), W'(0));
        check("rst_num", bus.out_num, W'(0));
        check("rst_den", bus.out_den, W'(0));
        check("rst_err", W'(bus.out_err), W'(0));
        check("rst_ready", W'(bus.in_ready), W'(1));
        rst = 1'b0;
        tick();

        send(W'(6), W'(4));                 collect("6_4", 37);
        send(32'hFFFF_FFF4, W'(18));         collect("m12_18", -1);
        send(W'(17), W'(13));                collect("17_13", -1);
        send(W'(0), W'(7));                  collect("0_7", 0);
        send(W'(5), W'(0));                  collect("5_0", 0);
        send(32'h8000_0000, W'(2));          collect("min_2", -1);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF);  collect("max_max", -1);

        // Backpressure: result held, new offer refused until handshake
        bus.out_ready = 1'b0;
        send(W'(8), W'(12));
        collect("8_12", -1);
        bus.in_num   = W'(9);
        bus.in_den   = W'(6);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", W'(bus.out_valid), W'(1));
            check("bp_num", bus.out_num, last_exp.num);
            check("bp_den", bus.out_den, last_exp.den);
            check("bp_ready", W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        hs_cyc = cyc;
        check("bp_taken", W'(bus.out_valid), W'(0));
        check("bp_idle", W'(bus.in_ready), W'(1));
        check("bp_hold_num", bus.out_num, last_exp.num);
        send(W'(9), W'(6));
        check("bp_accept_gap", W'(acc_cyc - hs_cyc), W'(1));
        check("bp_accepted", W'(bus.in_ready), W'(0));
        collect("9_6", -1);

        // Reset in the middle of the divide phase
        send(W'(100), W'(75));
        void'(sb.pop_back());
        for (int i = 0; i < 20; i++) tick();
        rst          = 1'b1;
        bus.in_num   = W'(1);
        bus.in_den   = W'(2);
        bus.in_valid = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_rst_valid", W'(bus.out_valid), W'(0));
        check("mid_rst_num", bus.out_num, W'(0));
        check("mid_rst_den", bus.out_den, W'(0));
        check("mid_rst_err", W'(bus.out_err), W'(0));
        check("mid_rst_ready", W'(bus.in_ready), W'(1));
        spur = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.out_valid) spur++;
        end
        check("mid_rst_spurious", W'(spur), W'(0));
        send(W'(9), W'(3));
        collect("9_3", -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
